student_tlul_arb: RTL

STUDENT_TLUL_ARB -- requirements
Module: student_tlul_arb

---
 rtl/student_tlul_arb_pkg.sv | 16 +
 rtl/tlul_pkg.sv | 41 ++++
 rtl/student_tlul_arb_if.sv | 21 ++
 rtl/student_rr_arbiter.sv | 32 +++
 rtl/student_tlul_arb.sv | 100 ++++++++++
 5 files changed

// File: rtl/student_tlul_arb_pkg.sv
// student_tlul_arb_pkg: index-width and round-robin helpers for the TL-UL arbiter.
// Latency: n/a (functions only).
// Backpressure: n/a (functions only).
package student_tlul_arb_pkg;

  // Width of a host index; never narrower than one bit.
  function automatic int idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  // Host examined at step 'off' of a search that starts just after 'last'.
  function automatic int rr_idx(input int last, input int off, input int num);
    return (last + off) % num;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: TileLink-UL channel types shared by hosts, devices and interconnect.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_arb_if.sv
// student_tlul_arb_if: bundles the NUM host-side links and the shared device link.
// Latency: n/a (wires only).
// Backpressure: n/a (carries a_ready/d_ready unchanged).
interface student_tlul_arb_if #(
  parameter int NUM = 2
);
  import tlul_pkg::*;

  tl_h2d_t host_h2d [NUM];
  tl_d2h_t host_d2h [NUM];
  tl_h2d_t dev_h2d;
  tl_d2h_t dev_d2h;

  // Host side: issues A-channel, consumes D-channel.
  modport master (output host_h2d, input host_d2h);
  // Device side: consumes A-channel, issues D-channel.
  modport slave (input dev_h2d, output dev_d2h);
  // Arbiter view: sits between all hosts and the device.
  modport arb (input host_h2d, output host_d2h, output dev_h2d, input dev_d2h);

endinterface

// File: rtl/student_rr_arbiter.sv
// student_rr_arbiter: picks the first requester after 'last', wrapping modulo NUM.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the grant.
module student_rr_arbiter
  import student_tlul_arb_pkg::*;
#(
  parameter int NUM = 2
) (
  input  logic [NUM-1:0]          req_i,
  input  logic [idx_w(NUM)-1:0]   last_i,
  output logic [idx_w(NUM)-1:0]   gnt_o,
  output logic                    vld_o
);
  localparam int IW = idx_w(NUM);

  logic [IW-1:0] cand;

  // Walk last+1, last+2, ... last+NUM and keep the first host that requests.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM; k++) begin
      cand = IW'(rr_idx(int'(last_i), k, NUM));
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        gnt_o = cand;
      end
    end
  end

endmodule

// File: rtl/student_tlul_arb.sv
// student_tlul_arb: shares one TL-UL device port among NUM hosts, one transaction in flight.
// Latency: 1 cycle to arbitrate (IDLE->ADDR); A and D channels then pass through combinationally.
// Backpressure: device a_ready and host d_ready reach only the granted host; all others stall.
module student_tlul_arb
  import tlul_pkg::*;
  import student_tlul_arb_pkg::*;
#(
  parameter int NUM = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_host_i [NUM],
  output tl_d2h_t tl_host_o [NUM],
  output tl_h2d_t tl_device_o,
  input  tl_d2h_t tl_device_i
);
  localparam int IW = idx_w(NUM);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [NUM-1:0] req;
  logic [IW-1:0] rr_gnt;
  logic          rr_vld;

  // Collect the per-host A-channel valids for the round-robin search.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM; i++) begin
      req[i] = tl_host_i[i].a_valid;
    end
  end

  student_rr_arbiter #(.NUM(NUM)) u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .vld_o  (rr_vld)
  );

  // State, grant and last-grant registers; reset points last at NUM-1 so host 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and routing; everything not explicitly connected is held at zero.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    tl_device_o = '0;
    for (int i = 0; i < NUM; i++) begin
      tl_host_o[i] = '0;
    end

    case (state_q)
      IDLE: begin
        // Any device response seen here is left unconsumed and unforwarded.
        if (rr_vld) begin
          grant_d = rr_gnt;
          state_d = ADDR;
        end
      end

      ADDR: begin
        // A-channel passthrough; a host dropping a_valid just stalls here.
        tl_device_o                = tl_host_i[grant_q];
        tl_device_o.d_ready        = 1'b0;
        tl_host_o[grant_q].a_ready = tl_device_i.a_ready;
        if (tl_host_i[grant_q].a_valid && tl_device_i.a_ready) begin
          state_d = RESP;
        end
      end

      RESP: begin
        // D-channel passthrough to the granted host only.
        tl_host_o[grant_q]         = tl_device_i;
        tl_host_o[grant_q].a_ready = 1'b0;
        tl_device_o.d_ready        = tl_host_i[grant_q].d_ready;
        if (tl_device_i.d_valid && tl_host_i[grant_q].d_ready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
